// File: rtl/id_pkg.sv
// rtl/id_pkg.sv - Shared constants for the ID/issue stage: forwarding selects, control bit positions, field ranges.
package id_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EXE = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_LD  = 2'b11;

  // ctl = {wreg, sld, wmem, regrt, aluimm, sext, shift}
  localparam int CTL_W      = 7;
  localparam int CTL_WREG   = 6;
  localparam int CTL_SLD    = 5;
  localparam int CTL_WMEM   = 4;
  localparam int CTL_REGRT  = 3;
  localparam int CTL_ALUIMM = 2;
  localparam int CTL_SEXT   = 1;
  localparam int CTL_SHIFT  = 0;

  localparam int OP_HI  = 31;
  localparam int OP_LO  = 26;
  localparam int JT_HI  = 25;
  localparam int RD_LO  = 10;
  localparam int IMM_LO = 10;
  localparam int RS_LO  = 5;
  localparam int RT_LO  = 0;

endpackage

// File: rtl/id_hazard_unit.sv
// rtl/id_hazard_unit.sv - Combinational source/producer compare giving forwarding selects and load-use stall.
module id_hazard_unit
  import id_pkg::*;
#(
  parameter int RAW = 5
) (
  input  logic [RAW-1:0] rs,
  input  logic [RAW-1:0] rt,
  input  logic           use_a,
  input  logic           use_b,
  input  logic           p1_valid,
  input  logic [RAW-1:0] p1_rn,
  input  logic           p1_ld,
  input  logic           p2_valid,
  input  logic [RAW-1:0] p2_rn,
  input  logic           p2_ld,
  output logic [1:0]     a_ctrl,
  output logic [1:0]     b_ctrl,
  output logic           stall
);

  logic a_p1, a_p2, b_p1, b_p2;

  assign a_p1 = use_a & p1_valid & (p1_rn == rs);
  assign a_p2 = use_a & p2_valid & (p2_rn == rs);
  assign b_p1 = use_b & p1_valid & (p1_rn == rt);
  assign b_p2 = use_b & p2_valid & (p2_rn == rt);

  // A P1 load match stalls, so its select value is never captured.
  always_comb begin
    a_ctrl = FWD_RF;
    b_ctrl = FWD_RF;
    if (a_p1 && !p1_ld) a_ctrl = FWD_EXE;
    else if (a_p2)      a_ctrl = p2_ld ? FWD_LD : FWD_MEM;
    if (b_p1 && !p1_ld) b_ctrl = FWD_EXE;
    else if (b_p2)      b_ctrl = p2_ld ? FWD_LD : FWD_MEM;
  end

  assign stall = p1_ld & (a_p1 | b_p1);

endmodule

// File: rtl/id_issue_stage.sv
// rtl/id_issue_stage.sv - Decode/issue stage with scoreboard forwarding, ID/EXE register; optional ID_WB_BYPASS_EN.
module id_issue_stage
  import id_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RAW  = 5,
  parameter int IMMW = 16
) (
  input  logic            clk,
  input  logic            clrn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] pc4,
  input  logic [31:0]     inst,
  input  logic [XLEN-1:0] qa,
  input  logic [XLEN-1:0] qb,
  input  logic [6:0]      ctl,
  input  logic [2:0]      aluop_in,
  input  logic            flush,
  input  logic            wb_wreg,
  input  logic [RAW-1:0]  wb_rn,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] a,
  output logic [XLEN-1:0] b,
  output logic [XLEN-1:0] imm,
  output logic [XLEN-1:0] bpc,
  output logic [XLEN-1:0] jpc,
  output logic [1:0]      a_ctrl,
  output logic [1:0]      b_ctrl,
  output logic [RAW-1:0]  rd_out,
  output logic            wreg,
  output logic            sld,
  output logic            wmem,
  output logic [2:0]      aluop,
  output logic            stall
);

  logic [5:0]      op;
  logic [RAW-1:0]  rs, rt, rd, dest;
  logic            c_wmem, c_regrt, c_aluimm, c_sext, c_shift;
  logic            use_a, use_b, capture;
  logic [XLEN-1:0] imm_nxt, bpc_nxt, jpc_nxt, a_nxt, b_nxt;
  logic [1:0]      a_sel, b_sel;
  logic            sb_valid, sb_ld;
  logic [RAW-1:0]  sb_rn;
  logic            unused_ok;

  assign op   = inst[OP_HI:OP_LO];
  assign rs   = inst[RS_LO +: RAW];
  assign rt   = inst[RT_LO +: RAW];
  assign rd   = inst[RD_LO +: RAW];

  assign c_wmem   = ctl[CTL_WMEM];
  assign c_regrt  = ctl[CTL_REGRT];
  assign c_aluimm = ctl[CTL_ALUIMM];
  assign c_sext   = ctl[CTL_SEXT];
  assign c_shift  = ctl[CTL_SHIFT];
  assign dest     = c_regrt ? rt : rd;

  assign imm_nxt = {{(XLEN-IMMW){c_sext & inst[IMMW+IMM_LO-1]}}, inst[IMMW+IMM_LO-1:IMM_LO]};
  assign bpc_nxt = pc4 + (imm_nxt << 2);
  assign jpc_nxt = {pc4[XLEN-1:28], inst[JT_HI:0], 2'b00};

  // Stores read rt as data even with an immediate ALU operand.
  assign use_a = ~c_shift & (rs != '0);
  assign use_b = ~(c_aluimm & ~c_wmem) & (rt != '0);

  id_hazard_unit #(.RAW(RAW)) u_hazard (
    .rs       (rs),
    .rt       (rt),
    .use_a    (use_a),
    .use_b    (use_b),
    .p1_valid (out_valid & wreg),
    .p1_rn    (rd_out),
    .p1_ld    (sld),
    .p2_valid (sb_valid),
    .p2_rn    (sb_rn),
    .p2_ld    (sb_ld),
    .a_ctrl   (a_sel),
    .b_ctrl   (b_sel),
    .stall    (stall)
  );

`ifdef ID_WB_BYPASS_EN
  assign a_nxt = (wb_wreg && (wb_rn != '0) && (wb_rn == rs)) ? wb_data : qa;
  assign b_nxt = (wb_wreg && (wb_rn != '0) && (wb_rn == rt)) ? wb_data : qb;
  assign unused_ok = ^{op};
`else
  assign a_nxt = qa;
  assign b_nxt = qb;
  assign unused_ok = ^{op, wb_wreg, wb_rn, wb_data};
`endif

  assign in_ready = (~out_valid | out_ready) & ~stall & ~flush;
  assign capture  = in_valid & in_ready;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      out_valid <= 1'b0;
      a         <= '0;
      b         <= '0;
      imm       <= '0;
      bpc       <= '0;
      jpc       <= '0;
      a_ctrl    <= FWD_RF;
      b_ctrl    <= FWD_RF;
      rd_out    <= '0;
      wreg      <= 1'b0;
      sld       <= 1'b0;
      wmem      <= 1'b0;
      aluop     <= '0;
      sb_valid  <= 1'b0;
      sb_rn     <= '0;
      sb_ld     <= 1'b0;
    end else begin
      if (flush) begin
        out_valid <= 1'b0;
      end else if (capture) begin
        out_valid <= 1'b1;
        a         <= a_nxt;
        b         <= b_nxt;
        imm       <= imm_nxt;
        bpc       <= bpc_nxt;
        jpc       <= jpc_nxt;
        a_ctrl    <= a_sel;
        b_ctrl    <= b_sel;
        rd_out    <= dest;
        wreg      <= ctl[CTL_WREG];
        sld       <= ctl[CTL_SLD];
        wmem      <= c_wmem;
        aluop     <= aluop_in;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      // sb0 tracks whatever EXE accepted on this edge.
      if (out_ready) begin
        sb_valid <= out_valid & wreg;
        sb_rn    <= rd_out;
        sb_ld    <= sld;
      end
    end
  end

endmodule

// File: tb/tb_id_issue_stage.sv
// tb/tb_id_issue_stage.sv - Directed self-checking bench for id_issue_stage.
module tb_id_issue_stage;

  logic        clk = 1'b0;
  logic        clrn;
  logic        in_valid, in_ready;
  logic [31:0] pc4, inst, qa, qb;
  logic [6:0]  ctl;
  logic [2:0]  aluop_in;
  logic        flush, wb_wreg;
  logic [4:0]  wb_rn;
  logic [31:0] wb_data;
  logic        out_valid, out_ready;
  logic [31:0] a, b, imm, bpc, jpc;
  logic [1:0]  a_ctrl, b_ctrl;
  logic [4:0]  rd_out;
  logic        wreg, sld, wmem;
  logic [2:0]  aluop;
  logic        stall;

  int checks = 0;
  int errors = 0;

  localparam logic [6:0] CTL_ALU  = 7'b1000000;
  localparam logic [6:0] CTL_LD   = 7'b1101110;
  localparam logic [6:0] CTL_ALUI = 7'b1001100;
  localparam logic [6:0] CTL_SX   = 7'b0000010;
  localparam logic [6:0] CTL_ZX   = 7'b0000000;

  id_issue_stage dut (
    .clk(clk), .clrn(clrn), .in_valid(in_valid), .in_ready(in_ready),
    .pc4(pc4), .inst(inst), .qa(qa), .qb(qb), .ctl(ctl), .aluop_in(aluop_in),
    .flush(flush), .wb_wreg(wb_wreg), .wb_rn(wb_rn), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .a(a), .b(b), .imm(imm),
    .bpc(bpc), .jpc(jpc), .a_ctrl(a_ctrl), .b_ctrl(b_ctrl), .rd_out(rd_out),
    .wreg(wreg), .sld(sld), .wmem(wmem), .aluop(aluop), .stall(stall)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rtype(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
    return {17'd0, rd, rs, rt};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] i, input logic [6:0] c, input logic [31:0] va, input logic [31:0] vb);
    in_valid = 1'b1;
    inst     = i;
    ctl      = c;
    qa       = va;
    qb       = vb;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    inst = '0;
    ctl = '0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    clrn = 1'b0; in_valid = 1'b0; pc4 = '0; inst = '0; qa = '0; qb = '0; ctl = '0;
    aluop_in = '0; flush = 1'b0; wb_wreg = 1'b0; wb_rn = '0; wb_data = '0; out_ready = 1'b1;
    #2;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (a_ctrl !== 2'b00 || b_ctrl !== 2'b00) begin errors++; $display("FAIL reset_ctrl got %b/%b want 00/00", a_ctrl, b_ctrl); end
    checks++; if (imm !== 32'h0 || a !== 32'h0) begin errors++; $display("FAIL reset_payload got imm=%h a=%h want 0", imm, a); end
    checks++; if (in_ready !== 1'b1 || stall !== 1'b0) begin errors++; $display("FAIL reset_ready got rdy=%b stall=%b want 1/0", in_ready, stall); end
    #10 clrn = 1'b1;
    tick();
  endtask

  task automatic test_alu_dep();
    aluop_in = 3'd5;
    drive(rtype(5'd3, 5'd1, 5'd2), CTL_ALU, 32'hA1, 32'hB1);
    tick();
    aluop_in = 3'd2;
    drive(rtype(5'd5, 5'd3, 5'd2), CTL_ALU, 32'hA2, 32'hB2);
    #1;
    checks++; if (stall !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL alu_dep_nostall got stall=%b rdy=%b want 0/1", stall, in_ready); end
    tick();
    checks++; if (a_ctrl !== 2'b01 || b_ctrl !== 2'b00) begin errors++; $display("FAIL alu_dep_ctrl got %b/%b want 01/00", a_ctrl, b_ctrl); end
    checks++; if (out_valid !== 1'b1 || rd_out !== 5'd5 || a !== 32'hA2 || aluop !== 3'd2) begin
      errors++; $display("FAIL alu_dep_payload got v=%b rd=%0d a=%h op=%0d want 1/5/a2/2", out_valid, rd_out, a, aluop); end
    idle(2);
  endtask

  task automatic test_two_apart();
    drive(rtype(5'd3, 5'd1, 5'd2), CTL_ALU, 32'h0, 32'h0); tick();
    drive(rtype(5'd5, 5'd6, 5'd7), CTL_ALU, 32'h0, 32'h0); tick();
    drive(rtype(5'd9, 5'd8, 5'd3), CTL_ALU, 32'h0, 32'h0); tick();
    checks++; if (a_ctrl !== 2'b00 || b_ctrl !== 2'b10) begin errors++; $display("FAIL two_apart got %b/%b want 00/10", a_ctrl, b_ctrl); end
    idle(2);
  endtask

  task automatic test_load_use();
    drive(rtype(5'd0, 5'd1, 5'd4), CTL_LD, 32'h0, 32'h0); tick();
    checks++; if (rd_out !== 5'd4 || sld !== 1'b1) begin errors++; $display("FAIL load_dest got rd=%0d sld=%b want 4/1", rd_out, sld); end
    drive(rtype(5'd6, 5'd4, 5'd2), CTL_ALU, 32'h0, 32'h0);
    #1;
    checks++; if (stall !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL load_use_stall got stall=%b rdy=%b want 1/0", stall, in_ready); end
    tick();
    checks++; if (out_valid !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL load_use_bubble got v=%b stall=%b want 0/0", out_valid, stall); end
    tick();
    checks++; if (out_valid !== 1'b1 || a_ctrl !== 2'b11 || rd_out !== 5'd6) begin
      errors++; $display("FAIL load_use_issue got v=%b a_ctrl=%b rd=%0d want 1/11/6", out_valid, a_ctrl, rd_out); end
    idle(2);
  endtask

  task automatic test_zero_imm();
    drive(rtype(5'd0, 5'd1, 5'd2), CTL_ALU, 32'h0, 32'h0); tick();
    drive(rtype(5'd8, 5'd0, 5'd9), CTL_ALU, 32'h0, 32'h0); tick();
    checks++; if (a_ctrl !== 2'b00) begin errors++; $display("FAIL zero_reg got %b want 00", a_ctrl); end
    idle(2);
    drive(rtype(5'd7, 5'd1, 5'd2), CTL_ALU, 32'h0, 32'h0); tick();
    drive(rtype(5'd0, 5'd1, 5'd7), CTL_ALUI, 32'h0, 32'h0); tick();
    checks++; if (b_ctrl !== 2'b00 || rd_out !== 5'd7) begin errors++; $display("FAIL aluimm_b got b=%b rd=%0d want 00/7", b_ctrl, rd_out); end
    idle(2);
    pc4 = 32'h100;
    drive({6'd0, 16'hFFFC, 10'd0}, CTL_SX, 32'h0, 32'h0); tick();
    checks++; if (imm !== 32'hFFFFFFFC || bpc !== 32'h000000F0) begin errors++; $display("FAIL sext_imm got imm=%h bpc=%h want fffffffc/000000f0", imm, bpc); end
    checks++; if (jpc !== 32'h0FFFC000) begin errors++; $display("FAIL jpc got %h want 0fffc000", jpc); end
    drive({6'd0, 16'hFFFC, 10'd0}, CTL_ZX, 32'h0, 32'h0); tick();
    checks++; if (imm !== 32'h0000FFFC || bpc !== 32'h000400F0) begin errors++; $display("FAIL zext_imm got imm=%h bpc=%h want 0000fffc/000400f0", imm, bpc); end
    pc4 = 32'h0;
    idle(2);
  endtask

  task automatic test_back_pressure();
    drive(rtype(5'd6, 5'd7, 5'd8), CTL_ALU, 32'h11, 32'h0); tick();
    out_ready = 1'b0;
    drive(rtype(5'd9, 5'd10, 5'd11), CTL_ALU, 32'h22, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (a !== 32'h11 || rd_out !== 5'd6 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++; $display("FAIL hold_%0d got a=%h rd=%0d v=%b rdy=%b want 11/6/1/0", i, a, rd_out, out_valid, in_ready); end
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_ready got %b want 1", in_ready); end
    tick();
    checks++; if (a !== 32'h22 || rd_out !== 5'd9) begin errors++; $display("FAIL release_capture got a=%h rd=%0d want 22/9", a, rd_out); end
  endtask

  task automatic test_flush();
    drive(rtype(5'd12, 5'd13, 5'd14), CTL_ALU, 32'h33, 32'h0);
    flush = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got %b want 0", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b0 || a !== 32'h22) begin errors++; $display("FAIL flush_kill got v=%b a=%h want 0/22", out_valid, a); end
    flush = 1'b0;
    idle(2);
  endtask

  task automatic test_reset_mid();
    drive(rtype(5'd1, 5'd2, 5'd3), CTL_ALU, 32'h0, 32'h0); tick();
    drive(rtype(5'd0, 5'd1, 5'd4), CTL_LD, 32'h0, 32'h0); tick();
    drive(rtype(5'd6, 5'd4, 5'd2), CTL_ALU, 32'h0, 32'h0);
    #1;
    checks++; if (stall !== 1'b1 || a_ctrl !== 2'b01) begin errors++; $display("FAIL pre_reset got stall=%b a_ctrl=%b want 1/01", stall, a_ctrl); end
    clrn = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || stall !== 1'b0 || a_ctrl !== 2'b00) begin
      errors++; $display("FAIL async_reset got v=%b stall=%b a_ctrl=%b want 0/0/00", out_valid, stall, a_ctrl); end
    #2 clrn = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready got %b want 1", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b1 || a_ctrl !== 2'b00 || b_ctrl !== 2'b00) begin
      errors++; $display("FAIL post_reset_sb got v=%b a=%b b=%b want 1/00/00", out_valid, a_ctrl, b_ctrl); end
    idle(2);
  endtask

  initial begin
    test_reset();
    test_alu_dep();
    test_two_apart();
    test_load_use();
    test_zero_imm();
    test_back_pressure();
    test_flush();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_issue_stage.md
Name: id_issue_stage

Overview:
- Parametrised successor of the instruction-decode stage.
- Splits instruction fields (op, func, rs, rt, rd, imm) and produces the immediate, branch target and jump target.
- Tracks in-flight destinations in an internal scoreboard, so A/B forwarding selects and load-use stalls are generated internally; no external depen vector.
- Holds the ID/EXE pipeline register with a valid/ready handshake and flush. Sits between IF and EXE, beside the existing Regfile and Control_Unit.

Parameters:
- XLEN, 32, datapath width; must be ≥ 32.
- RAW, 5, register-address width; register 0 is hardwired zero.
- IMMW, 16, immediate field width, taken from inst[IMMW+9:10].

Ports:
- clk in 1: clock.
- clrn in 1: reset.
- in_valid in 1: IF holds a valid instruction.
- in_ready out 1: stage accepts the IF instruction this cycle.
- pc4 in XLEN: PC+4 of the incoming instruction.
- inst in 32: instruction word.
- qa, qb in XLEN: Regfile read data for rs and rt.
- ctl in 7: {wreg, sld, wmem, regrt, aluimm, sext, shift} from Control_Unit.
- aluop_in in 3: ALU operation from Control_Unit.
- flush in 1: kill the in-flight ID instruction (taken branch or jump).
- wb_wreg in 1: write-back enable.
- wb_rn in RAW: write-back register number.
- wb_data in XLEN: write-back data.
- out_valid out 1: ID/EXE register holds a valid instruction.
- out_ready in 1: EXE accepts.
- a, b out XLEN: operand values.
- imm out XLEN: extended immediate.
- bpc, jpc out XLEN: branch target and jump target.
- a_ctrl, b_ctrl out 2: forwarding selects.
- rd_out out RAW: destination register.
- wreg, sld, wmem out 1: registered control bits.
- aluop out 3: registered ALU operation.
- stall out 1: load-use interlock active.

Behaviour:
- Reset: one clock, clk; reset clrn, asynchronous, active-low.
- While clrn=0, every output register and all scoreboard entries are 0; out_valid=0.
- Field split:
  - op = inst[31:26]
  - rs = inst[9:5]
  - rt = inst[4:0]
  - rd = inst[14:10]
  - dest = regrt ? rt : rd
- imm = sign extension when sext=1, otherwise zero extension, of inst[IMMW+9:10] to XLEN.
- bpc = pc4 + (imm << 2), truncated to XLEN.
- jpc = {pc4[XLEN-1:28], inst[25:0], 2'b00}.
- Source usage:
  - A uses rs unless shift=1.
  - B uses rt unless aluimm=1 and wmem=0.
  - Register 0 is never a dependency.
- Producers:
  - P1 is the ID/EXE register contents, when out_valid=1 and wreg=1.
  - P2 is scoreboard entry sb0, the last instruction handed to EXE.
- Forwarding select for each used source, P1 checked before P2:
  - P1 match and not a load: 01 (EXE ALU result).
  - P2 match and a load: 11 (MEM load data).
  - P2 match and not a load: 10 (MEM ALU result).
  - No match: 00 (register file).
- Load-use interlock: stall=1 when P1 is a load (sld=1) and matches a used source.
- in_ready = (~out_valid | out_ready) & ~stall & ~flush.
- Capture: on in_valid & in_ready, all payload and out_valid=1 load at the rising clock edge. Latency is 1 cycle.
- Drain: out_valid & out_ready without a capture gives out_valid=0 (bubble). A stall therefore inserts exactly one bubble.
- Hold: out_valid & ~out_ready keeps the payload unchanged. This is a hard back-pressure rule.
- Scoreboard: on every edge with out_ready=1, sb0 ← {out_valid & wreg, rd_out, sld}; with out_ready=0, sb0 holds.
- Flush: flush=1 at an edge clears out_valid, captures nothing, and the scoreboard still shifts. Flush wins over a simultaneous capture or stall.
- Write-back in the same cycle as the read is handled by the Regfile's negedge write. Optional bypass below.
- Reset mid-operation: all state clears immediately; the first post-reset cycle has in_ready=1.

Optional Feature:
- Macro: ID_WB_BYPASS_EN.
- Defined: when wb_wreg=1, wb_rn≠0 and wb_rn equals rs (or rt), a (or b) captures wb_data instead of qa (or qb). This supports a posedge-write Regfile.
- Undefined: a=qa and b=qb unconditionally.

Decomposition:
- Shared package id_pkg holds:
  - forwarding-select constants FWD_RF=00, FWD_EXE=01, FWD_MEM=10, FWD_LD=11
  - control-bundle bit positions
  - the instruction field bit ranges
- One natural sub-module, id_hazard_unit: combinational compare of rs/rt against P1 and P2, producing a_ctrl, b_ctrl and stall.
- The top holds field split, immediate/target arithmetic, the pipeline register and the scoreboard.

Test Plan:
- ALU then dependent ALU: I1 writes r3, I2 reads rs=r3 → I2 a_ctrl=01, no stall.
- Two-apart dependency: I1 writes r3, unrelated I2, I3 reads rt=r3 (aluimm=0) → I3 b_ctrl=10.
- Load-use: I1 is a load to r4, I2 uses rs=r4 → stall=1 for one cycle, one bubble (out_valid=0), then I2 issues with a_ctrl=11.
- Zero register and immediates:
  - I1 writes r0, I2 reads r0 → a_ctrl=00.
  - aluimm=1 with rt matching → b_ctrl=00.
  - sext=1, inst[25:10]=0xFFFC, pc4=0x100 → imm=0xFFFFFFFC, bpc=0xF0.
- Back-pressure and flush:
  - out_ready=0 for 3 cycles → payload stable, in_ready=0.
  - flush with in_valid=1 → out_valid=0 next cycle, nothing captured.
- Reset: clrn low mid-stall → out_valid, stall, a_ctrl and scoreboard become 0 immediately without a clock edge.
